// File: rtl/pic_pkg.sv
// Shared definitions for the structural PIC core.
// Contents:
//   PIC_ADDR_W, PIC_DATA_W  default program-address and data-bus widths
//   PIC_STACK_DEPTH         default return-stack depth
//   pc_action_e             PC action encoding shared by the decoder and PC unit
package pic_pkg;

  localparam int unsigned PIC_ADDR_W      = 9;
  localparam int unsigned PIC_DATA_W      = 8;
  localparam int unsigned PIC_STACK_DEPTH = 2;

  typedef enum logic [2:0] {
    PC_WRITE,
    PC_PUSH,
    PC_POP,
    PC_LOAD,
    PC_SKIP,
    PC_HOLD,
    PC_INC
  } pc_action_e;

endpackage

// File: rtl/pc_ret_stack_unit_shift_stack.sv
// pc_shift_stack: shift-register return stack with level counter and
// sticky error flags. Entry 0 is the top of stack.
// Ports:
//   clock, reset     rising-edge clock, asynchronous active-low reset
//   do_push, do_pop  priority-resolved single-cycle strobes (never both)
//   push_val         value written to entry 0 on push
//   clr_err          clear overflow/underflow (a same-cycle error wins)
//   top              entry 0
//   level            number of valid entries
//   full, empty      level == STACK_DEPTH / level == 0
//   overflow, underflow  sticky error flags
module pc_shift_stack
  import pic_pkg::*;
#(
  parameter int unsigned ADDR_W      = PIC_ADDR_W,
  parameter int unsigned STACK_DEPTH = PIC_STACK_DEPTH
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               do_push,
  input  logic                               do_pop,
  input  logic [ADDR_W-1:0]                  push_val,
  input  logic                               clr_err,
  output logic [ADDR_W-1:0]                  top,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   level,
  output logic                               full,
  output logic                               empty,
  output logic                               overflow,
  output logic                               underflow
);

  localparam int unsigned LVL_W = $clog2(STACK_DEPTH + 1);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(STACK_DEPTH);

  logic [ADDR_W-1:0] stk_q [STACK_DEPTH];
  logic [LVL_W-1:0]  lvl_q, lvl_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              is_full, is_empty;

  assign is_full  = (lvl_q == FULL_LVL);
  assign is_empty = (lvl_q == '0);

  always_comb begin
    lvl_d = lvl_q;
    ovf_d = clr_err ? 1'b0 : ovf_q;
    unf_d = clr_err ? 1'b0 : unf_q;
    if (do_push) begin
      if (is_full) ovf_d = 1'b1;
      else         lvl_d = lvl_q + 1'b1;
    end else if (do_pop) begin
      if (is_empty) unf_d = 1'b1;
      else          lvl_d = lvl_q - 1'b1;
    end
  end

  // On pop the deepest entry keeps its value, so it ends up duplicated.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < STACK_DEPTH; i++) stk_q[i] <= '0;
      lvl_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (do_push) begin
        stk_q[0] <= push_val;
        for (int unsigned i = 1; i < STACK_DEPTH; i++) stk_q[i] <= stk_q[i-1];
      end else if (do_pop) begin
        for (int unsigned i = 0; i + 1 < STACK_DEPTH; i++) stk_q[i] <= stk_q[i+1];
      end
      lvl_q <= lvl_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign top       = stk_q[0];
  assign level     = lvl_q;
  assign full      = is_full;
  assign empty     = is_empty;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: rtl/pc_ret_stack_unit.sv
// pc_ret_stack_unit: program counter with return stack, skip/hold control
// and stack-health flags.
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-low reset
//   out_en              drive pc low byte on data_out, else high-Z
//   write_en, data_in   computed jump to zero-extended data_in
//   push, pop           call (to data_in, pushing pc) / return (from top)
//   load, addr_in       absolute jump to addr_in
//   skip, hold          pc+2 / stall
//   clr_err             clear sticky flags
//   addr_out, data_out  current pc / tri-state pc low bits
//   stack_level, stack_full, stack_empty, overflow, underflow  stack status
// Priority: write_en > push > pop > load > skip > hold > increment.
module pc_ret_stack_unit
  import pic_pkg::*;
#(
  parameter int unsigned       ADDR_W      = PIC_ADDR_W,
  parameter int unsigned       DATA_W      = PIC_DATA_W,
  parameter int unsigned       STACK_DEPTH = PIC_STACK_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_VEC   = '0
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              out_en,
  input  logic                              write_en,
  input  logic [DATA_W-1:0]                 data_in,
  output logic [DATA_W-1:0]                 data_out,
  input  logic [ADDR_W-1:0]                 addr_in,
  output logic [ADDR_W-1:0]                 addr_out,
  input  logic                              push,
  input  logic                              pop,
  input  logic                              load,
  input  logic                              skip,
  input  logic                              hold,
  input  logic                              clr_err,
  output logic [$clog2(STACK_DEPTH+1)-1:0]  stack_level,
  output logic                              stack_full,
  output logic                              stack_empty,
  output logic                              overflow,
  output logic                              underflow
);

  pc_action_e        action;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] stk_top;
  logic              do_push, do_pop;

  always_comb begin
    if      (write_en) action = PC_WRITE;
    else if (push)     action = PC_PUSH;
    else if (pop)      action = PC_POP;
    else if (load)     action = PC_LOAD;
    else if (skip)     action = PC_SKIP;
    else if (hold)     action = PC_HOLD;
    else               action = PC_INC;
  end

  // Only the winning action may touch the stack; masked push/pop are dropped.
  assign do_push = (action == PC_PUSH);
  assign do_pop  = (action == PC_POP);

  always_comb begin
    pc_d = pc_q;
    case (action)
      PC_WRITE: pc_d = ADDR_W'(data_in);
      PC_PUSH:  pc_d = ADDR_W'(data_in);
      PC_POP:   pc_d = stk_top;
      PC_LOAD:  pc_d = addr_in;
      PC_SKIP:  pc_d = pc_q + ADDR_W'(2);
      PC_HOLD:  pc_d = pc_q;
      default:  pc_d = pc_q + ADDR_W'(1);
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) pc_q <= RESET_VEC;
    else        pc_q <= pc_d;
  end

  pc_shift_stack #(
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clock     (clock),
    .reset     (reset),
    .do_push   (do_push),
    .do_pop    (do_pop),
    .push_val  (pc_q),
    .clr_err   (clr_err),
    .top       (stk_top),
    .level     (stack_level),
    .full      (stack_full),
    .empty     (stack_empty),
    .overflow  (overflow),
    .underflow (underflow)
  );

  assign addr_out = pc_q;
  assign data_out = out_en ? pc_q[DATA_W-1:0] : 'z;

endmodule

// File: tb/tb_pc_ret_stack_unit.sv
module tb_pc_ret_stack_unit;

  localparam int unsigned AW = 9;
  localparam int unsigned DW = 8;
  localparam int unsigned SD = 2;

  // control bit positions in the vector ctl field
  localparam logic [7:0] IDLE = 8'h00, OE = 8'h80, WE = 8'h40, PU = 8'h20,
                         PO = 8'h10, LD = 8'h08, SK = 8'h04, HO = 8'h02, CL = 8'h01;

  typedef struct {
    logic [7:0]    ctl;
    logic [DW-1:0] din;
    logic [AW-1:0] ain;
    logic [AW-1:0] exp_pc;
    logic [1:0]    exp_lvl;
    logic          exp_ovf;
    logic          exp_unf;
  } vec_t;

  logic          clock, reset;
  logic          out_en, write_en, push, pop, load, skip, hold, clr_err;
  logic [DW-1:0] data_in, data_out;
  logic [AW-1:0] addr_in, addr_out;
  logic [1:0]    stack_level;
  logic          stack_full, stack_empty, overflow, underflow;

  int total = 0;
  int bad   = 0;
  vec_t tbl[$];
  vec_t sb[$];

  pc_ret_stack_unit #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .STACK_DEPTH (SD),
    .RESET_VEC   (9'h000)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .out_en      (out_en),
    .write_en    (write_en),
    .data_in     (data_in),
    .data_out    (data_out),
    .addr_in     (addr_in),
    .addr_out    (addr_out),
    .push        (push),
    .pop         (pop),
    .load        (load),
    .skip        (skip),
    .hold        (hold),
    .clr_err     (clr_err),
    .stack_level (stack_level),
    .stack_full  (stack_full),
    .stack_empty (stack_empty),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t v(input logic [7:0] ctl, input logic [DW-1:0] din,
                             input logic [AW-1:0] ain, input logic [AW-1:0] pc,
                             input logic [1:0] lvl, input logic ovf, input logic unf);
    vec_t r;
    r.ctl = ctl; r.din = din; r.ain = ain;
    r.exp_pc = pc; r.exp_lvl = lvl; r.exp_ovf = ovf; r.exp_unf = unf;
    return r;
  endfunction

  task automatic drive(input vec_t x);
    out_en   = x.ctl[7];
    write_en = x.ctl[6];
    push     = x.ctl[5];
    pop      = x.ctl[4];
    load     = x.ctl[3];
    skip     = x.ctl[2];
    hold     = x.ctl[1];
    clr_err  = x.ctl[0];
    data_in  = x.din;
    addr_in  = x.ain;
  endtask

  task automatic compare_state(input string tag, input vec_t e);
    logic [31:0] exp_dout;
    exp_dout = e.ctl[7] ? {24'h0, e.exp_pc[DW-1:0]} : {24'h0, 8'hzz};
    chk({tag, " addr_out"},    {23'h0, addr_out},    {23'h0, e.exp_pc});
    chk({tag, " stack_level"}, {30'h0, stack_level}, {30'h0, e.exp_lvl});
    chk({tag, " stack_full"},  {31'h0, stack_full},  {31'h0, (e.exp_lvl == 2'd2)});
    chk({tag, " stack_empty"}, {31'h0, stack_empty}, {31'h0, (e.exp_lvl == 2'd0)});
    chk({tag, " overflow"},    {31'h0, overflow},    {31'h0, e.exp_ovf});
    chk({tag, " underflow"},   {31'h0, underflow},   {31'h0, e.exp_unf});
    chk({tag, " data_out"},    {24'h0, data_out},    exp_dout);
  endtask

  // Drive one vector, queue its expectation, take the edge and check.
  task automatic step(input string tag, input vec_t x);
    vec_t e;
    drive(x);
    sb.push_back(x);
    @(posedge clock);
    #1;
    e = sb.pop_front();
    compare_state(tag, e);
  endtask

  initial begin
    drive(v(IDLE, 8'h00, 9'h000, 9'h000, 2'd0, 1'b0, 1'b0));
    reset = 1'b0;
    #12;
    compare_state("reset", v(IDLE, 8'h00, 9'h000, 9'h000, 2'd0, 1'b0, 1'b0));
    @(negedge clock);
    reset = 1'b1;

    //             ctl      din    ain     pc      lvl  ovf  unf
    tbl.push_back(v(IDLE,    8'h00, 9'h000, 9'h001, 2'd0, 1'b0, 1'b0));
    tbl.push_back(v(IDLE,    8'h00, 9'h000, 9'h002, 2'd0, 1'b0, 1'b0));
    tbl.push_back(v(OE,      8'h00, 9'h000, 9'h003, 2'd0, 1'b0, 1'b0));
    tbl.push_back(v(LD|OE,   8'h00, 9'h1FF, 9'h1FF, 2'd0, 1'b0, 1'b0));
    tbl.push_back(v(IDLE,    8'h00, 9'h000, 9'h000, 2'd0, 1'b0, 1'b0));
    tbl.push_back(v(LD,      8'h00, 9'h1FF, 9'h1FF, 2'd0, 1'b0, 1'b0));
    tbl.push_back(v(SK,      8'h00, 9'h000, 9'h001, 2'd0, 1'b0, 1'b0));
    tbl.push_back(v(LD,      8'h00, 9'h010, 9'h010, 2'd0, 1'b0, 1'b0));
    tbl.push_back(v(PU,      8'h40, 9'h000, 9'h040, 2'd1, 1'b0, 1'b0));
    tbl.push_back(v(IDLE,    8'h00, 9'h000, 9'h041, 2'd1, 1'b0, 1'b0));
    tbl.push_back(v(PU,      8'h80, 9'h000, 9'h080, 2'd2, 1'b0, 1'b0));
    tbl.push_back(v(PO,      8'h00, 9'h000, 9'h041, 2'd1, 1'b0, 1'b0));
    tbl.push_back(v(IDLE,    8'h00, 9'h000, 9'h042, 2'd1, 1'b0, 1'b0));
    tbl.push_back(v(PO,      8'h00, 9'h000, 9'h010, 2'd0, 1'b0, 1'b0));
    tbl.push_back(v(IDLE,    8'h00, 9'h000, 9'h011, 2'd0, 1'b0, 1'b0));
    tbl.push_back(v(LD,      8'h00, 9'h005, 9'h005, 2'd0, 1'b0, 1'b0));
    tbl.push_back(v(PU,      8'hA0, 9'h000, 9'h0A0, 2'd1, 1'b0, 1'b0));
    tbl.push_back(v(IDLE,    8'h00, 9'h000, 9'h0A1, 2'd1, 1'b0, 1'b0));
    tbl.push_back(v(PU,      8'hB0, 9'h000, 9'h0B0, 2'd2, 1'b0, 1'b0));
    tbl.push_back(v(IDLE,    8'h00, 9'h000, 9'h0B1, 2'd2, 1'b0, 1'b0));
    tbl.push_back(v(PU,      8'hC0, 9'h000, 9'h0C0, 2'd2, 1'b1, 1'b0));
    tbl.push_back(v(PO,      8'h00, 9'h000, 9'h0B1, 2'd1, 1'b1, 1'b0));
    tbl.push_back(v(PO,      8'h00, 9'h000, 9'h0A1, 2'd0, 1'b1, 1'b0));
    tbl.push_back(v(PO,      8'h00, 9'h000, 9'h0A1, 2'd0, 1'b1, 1'b1));
    tbl.push_back(v(WE|PU,   8'h33, 9'h000, 9'h033, 2'd0, 1'b1, 1'b1));
    tbl.push_back(v(CL|PO,   8'h00, 9'h000, 9'h0A1, 2'd0, 1'b0, 1'b1));
    tbl.push_back(v(CL,      8'h00, 9'h000, 9'h0A2, 2'd0, 1'b0, 1'b0));
    tbl.push_back(v(WE|PO,   8'h33, 9'h000, 9'h033, 2'd0, 1'b0, 1'b0));
    tbl.push_back(v(LD,      8'h00, 9'h020, 9'h020, 2'd0, 1'b0, 1'b0));
    tbl.push_back(v(HO,      8'h00, 9'h000, 9'h020, 2'd0, 1'b0, 1'b0));
    tbl.push_back(v(HO,      8'h00, 9'h000, 9'h020, 2'd0, 1'b0, 1'b0));
    tbl.push_back(v(HO,      8'h00, 9'h000, 9'h020, 2'd0, 1'b0, 1'b0));
    tbl.push_back(v(HO,      8'h00, 9'h000, 9'h020, 2'd0, 1'b0, 1'b0));
    tbl.push_back(v(PU,      8'h50, 9'h000, 9'h050, 2'd1, 1'b0, 1'b0));
    tbl.push_back(v(HO|LD,   8'h00, 9'h100, 9'h100, 2'd1, 1'b0, 1'b0));
    tbl.push_back(v(HO,      8'h00, 9'h000, 9'h100, 2'd1, 1'b0, 1'b0));

    for (int i = 0; i < tbl.size(); i++)
      step($sformatf("vec%0d", i), tbl[i]);

    // Asynchronous reset in the middle of a hold, away from any edge.
    drive(v(HO, 8'h00, 9'h000, 9'h000, 2'd0, 1'b0, 1'b0));
    #2;
    reset = 1'b0;
    #1;
    compare_state("midreset", v(HO, 8'h00, 9'h000, 9'h000, 2'd0, 1'b0, 1'b0));
    @(negedge clock);
    reset = 1'b1;

    // Stack contents were discarded: an underflowing pop returns 0.
    step("post_pop",  v(PO,   8'h00, 9'h000, 9'h000, 2'd0, 1'b0, 1'b1));
    step("post_idle", v(IDLE, 8'h00, 9'h000, 9'h001, 2'd0, 1'b0, 1'b1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
